bcd_to_binary_seq: RTL and testbench

Multi-cycle packed-BCD to binary converter. It is the inverse of the lab's binary-to-decimal display path: operator-entered decimal digits from SW/keypad logic arrive as packed BCD and leave as a plain unsigned binary value for the arithmetic datapath. Conversion uses reverse double-dabble, one shift per clock. A start/busy/done handshake lets a slow front end, such as a debounced KEY press, launch conversions.

---
 rtl/bcd_to_binary_seq.sv | 120 ++++++++++++
 tb/tb_bcd_to_binary_seq.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_to_binary_seq.sv
// Sequential packed-BCD to unsigned binary converter (reverse double-dabble, one shift per clock).
// start/busy/done handshake; nibbles above 9 abort with err and a zero result.
module bcd_to_binary_seq #(
  parameter int unsigned DIGITS = 2,
  localparam int unsigned BW = (DIGITS == 1) ? 4 :
                               (DIGITS == 2) ? 7 :
                               (DIGITS == 3) ? 10 : 14
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [BW-1:0]         bin_out
);

  localparam int unsigned CW = $clog2(BW + 1);
  localparam logic [CW-1:0] LAST = CW'(BW - 1);

  localparam logic [1:0] st_idle  = 2'd0;
  localparam logic [1:0] st_shift = 2'd1;
  localparam logic [1:0] st_done  = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d;
  logic [BW-1:0]       bin_q, bin_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                errp_q, errp_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [BW-1:0]       bout_q, bout_d;

  logic                   bad_digit;
  logic [4*DIGITS+BW-1:0] shifted;
  logic [4*DIGITS-1:0]    bcd_sh, bcd_adj;
  logic [BW-1:0]          bin_sh;

  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (bcd_in[4*i +: 4] > 4'd9) bad_digit = 1'b1;
    end
  end

  // One reverse double-dabble step: shift right, then pull any nibble >= 8 back by 3.
  always_comb begin
    shifted = {bcd_q, bin_q} >> 1;
    bcd_sh  = shifted[BW +: 4*DIGITS];
    bin_sh  = shifted[BW-1:0];
    bcd_adj = bcd_sh;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (bcd_sh[4*i +: 4] >= 4'd8) bcd_adj[4*i +: 4] = bcd_sh[4*i +: 4] - 4'd3;
    end
  end

  always_comb begin
    state_d = state_q;
    bcd_d   = bcd_q;
    bin_d   = bin_q;
    cnt_d   = cnt_q;
    errp_d  = errp_q;
    done_d  = 1'b0;
    err_d   = err_q;
    bout_d  = bout_q;
    case (state_q)
      st_idle: begin
        if (start) begin
          bcd_d   = bcd_in;
          bin_d   = '0;
          cnt_d   = '0;
          errp_d  = bad_digit;
          state_d = bad_digit ? st_done : st_shift;
        end
      end
      st_shift: begin
        bcd_d = bcd_adj;
        bin_d = bin_sh;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) state_d = st_done;
      end
      st_done: begin
        done_d  = 1'b1;
        err_d   = errp_q;
        bout_d  = errp_q ? '0 : bin_q;
        state_d = st_idle;
      end
      default: state_d = st_idle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= st_idle;
      bcd_q   <= '0;
      bin_q   <= '0;
      cnt_q   <= '0;
      errp_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      bout_q  <= '0;
    end else begin
      state_q <= state_d;
      bcd_q   <= bcd_d;
      bin_q   <= bin_d;
      cnt_q   <= cnt_d;
      errp_q  <= errp_d;
      done_q  <= done_d;
      err_q   <= err_d;
      bout_q  <= bout_d;
    end
  end

  assign busy    = (state_q != st_idle);
  assign done    = done_q;
  assign err     = err_q;
  assign bin_out = bout_q;

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Self-checking bench for bcd_to_binary_seq: decimal-arithmetic reference model checked every
// cycle on a DIGITS=2 instance, plus directed literal checks on DIGITS=2 and DIGITS=3 instances.
module tb_bcd_to_binary_seq;

  localparam int BW2 = 7;
  localparam int BW3 = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, start3;
  logic [7:0]  bcd;
  logic [11:0] bcd3;
  logic        busy, done, err;
  logic        busy3, done3, err3;
  logic [6:0]  bout;
  logic [9:0]  bout3;

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;

  always #5 clk = ~clk;

  bcd_to_binary_seq #(.DIGITS(2)) u_dut2 (
    .CLK(clk), .RESET(rst), .start(start), .bcd_in(bcd),
    .busy(busy), .done(done), .err(err), .bin_out(bout)
  );

  bcd_to_binary_seq #(.DIGITS(3)) u_dut3 (
    .CLK(clk), .RESET(rst), .start(start3), .bcd_in(bcd3),
    .busy(busy3), .done(done3), .err(err3), .bin_out(bout3)
  );

  // Decimal value of a packed BCD word, or an error flag if any digit exceeds 9.
  function automatic void ref_conv(input logic [15:0] b, input int nd, output int val,
                                   output bit e);
    int n;
    val = 0;
    e   = 0;
    for (int i = nd - 1; i >= 0; i--) begin
      n = int'((b >> (4 * i)) & 16'hF);
      if (n > 9) e = 1;
      val = val * 10 + n;
    end
    if (e) val = 0;
  endfunction

  // Reference: a conversion keeps the block busy for a fixed number of cycles, then pulses done.
  int m_rem  = 0;
  bit m_done = 0;
  bit m_err  = 0;
  int m_bin  = 0;
  int p_val  = 0;
  bit p_err  = 0;

  initial forever begin
    @(posedge clk);
    if (rst) begin
      m_rem = 0; m_done = 0; m_err = 0; m_bin = 0;
    end else if (m_rem == 0) begin
      m_done = 0;
      if (start) begin
        ref_conv({8'h00, bcd}, 2, p_val, p_err);
        m_rem = p_err ? 1 : BW2 + 1;
      end
    end else begin
      m_rem--;
      if (m_rem == 0) begin
        m_done = 1; m_bin = p_val; m_err = p_err;
      end else begin
        m_done = 0;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      total++;
      if (busy !== (m_rem != 0) || done !== m_done || err !== m_err || bout !== 7'(m_bin)) begin
        bad++;
        $display("FAIL cycle_compare t=%0t got busy=%b done=%b err=%b bin=%0d want busy=%b done=%b err=%b bin=%0d",
                 $time, busy, done, err, bout, (m_rem != 0), m_done, m_err, m_bin);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic run2(input logic [7:0] b, input int want_bin, input bit want_err,
                      input int want_lat);
    int lat;
    int bc;
    @(negedge clk);
    bcd = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    bc = (busy === 1'b1) ? 1 : 0;
    while (done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
      if (busy === 1'b1) bc++;
    end
    chk($sformatf("lat_%h", b), lat, want_lat);
    chk($sformatf("busycyc_%h", b), bc, want_lat);
    chk($sformatf("bin_%h", b), {25'd0, bout}, want_bin);
    chk($sformatf("err_%h", b), {31'd0, err}, {31'd0, want_err});
  endtask

  task automatic run3(input logic [11:0] b, input int want_bin, input bit want_err,
                      input int want_lat);
    int lat;
    @(negedge clk);
    bcd3 = b; start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    lat = 0;
    while (done3 !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk($sformatf("d3_lat_%h", b), lat, want_lat);
    chk($sformatf("d3_bin_%h", b), {22'd0, bout3}, want_bin);
    chk($sformatf("d3_err_%h", b), {31'd0, err3}, {31'd0, want_err});
  endtask

  initial begin
    int dones;
    int seen_bin;
    rst = 1'b1; start = 1'b0; start3 = 1'b0; bcd = '0; bcd3 = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_err", {31'd0, err}, 0);
    chk("rst_bin", {25'd0, bout}, 0);
    chk_en = 1;
    rst = 1'b0;

    run2(8'h99, 99, 0, 8);
    run2(8'h00, 0, 0, 8);
    run2(8'h01, 1, 0, 8);
    run2(8'h10, 10, 0, 8);
    run2(8'h57, 57, 0, 8);
    run2(8'h80, 80, 0, 8);
    run2(8'h4A, 0, 1, 1);
    run2(8'h57, 57, 0, 8);
    run2(8'hF0, 0, 1, 1);
    run2(8'h42, 42, 0, 8);

    // start asserted during SHIFT and during DONE must be ignored
    @(negedge clk);
    bcd = 8'h25; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dones = 0; seen_bin = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin dones++; seen_bin = int'(bout); end
      start = (i == 2 || i == BW2) ? 1'b1 : 1'b0;
      if (start) bcd = 8'h63;
    end
    start = 1'b0;
    chk("busy_start_dones", dones, 1);
    chk("busy_start_bin", seen_bin, 25);
    chk("busy_start_final", {25'd0, bout}, 25);

    // reset sampled at the third SHIFT cycle
    @(negedge clk);
    bcd = 8'h77; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", {31'd0, busy}, 0);
    chk("midrst_done", {31'd0, done}, 0);
    chk("midrst_err", {31'd0, err}, 0);
    chk("midrst_bin", {25'd0, bout}, 0);
    dones = 0;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    chk("midrst_nodone", dones, 0);
    run2(8'h31, 31, 0, 8);

    run3(12'h999, 999, 0, BW3 + 1);
    run3(12'h305, 305, 0, BW3 + 1);
    run3(12'h9A0, 0, 1, 1);
    run3(12'h100, 100, 0, BW3 + 1);

    // start held high: relaunch every BW+2 cycles
    @(negedge clk);
    bcd = 8'h36; start = 1'b1;
    dones = 0;
    repeat (4 * (BW2 + 2)) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    start = 1'b0;
    chk("held_start_dones", dones, 4);

    repeat (400) begin
      @(negedge clk);
      start = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 7) == 0) bcd = 8'($urandom);
      else bcd = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      rst = ($urandom_range(0, 63) == 0);
    end
    @(negedge clk);
    start = 1'b0; rst = 1'b0;
    repeat (12) @(negedge clk);

    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
